// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : riscv_pkg
//  Purpose : Shared RV32I decode definitions: datapath width, base opcodes,
//            and the ALU operation encoding consumed by the execute stage.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MUL  = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
//  Module  : imm_gen
//  Purpose : Combinational RV32I immediate extraction. The format (I/S/B/U/J)
//            is chosen from the opcode; bit 31 always supplies the sign.
//            Opcodes without an immediate (R-type, unknown) yield zero.
//  Ports   : instruction - raw 32-bit instruction word
//            imm         - sign-extended 32-bit immediate
//  Rev     : 1.0  initial release
// ============================================================================
module imm_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] imm
);

  logic [6:0] opcode;
  logic       sign;

  assign opcode = instruction[6:0];
  assign sign   = instruction[31];

  always_comb begin
    imm = '0;
    case (opcode)
      OPC_I_ALU, OPC_LOAD, OPC_JALR:
        imm = {{20{sign}}, instruction[31:20]};
      OPC_STORE:
        imm = {{20{sign}}, instruction[31:25], instruction[11:7]};
      OPC_BRANCH:
        imm = {{19{sign}}, sign, instruction[7], instruction[30:25],
               instruction[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instruction[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{sign}}, sign, instruction[19:12], instruction[20],
               instruction[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
//  Module  : instruction_decode
//  Purpose : RV32I decode stage. A one-entry IF/ID register captures the
//            fetched PC and instruction under a valid/ready handshake; the
//            held word is decoded combinationally into register indices, an
//            immediate and control flags for execute. Flush drops both the
//            held word and any word offered in the same cycle.
//  Config  : DECODE_RV32M_EN - when defined, funct7=0000001 on the R opcode
//            decodes to the M-extension ops; otherwise those are illegal.
//  Ports   : clk, rst (async, active-low)
//            if_valid/if_pc/if_instruction/id_ready - fetch-side handshake
//            flush     - discard held and incoming instruction
//            ex_ready/id_valid - execute-side handshake
//            id_pc, rs1, rs2, rd, imm, funct3 - decoded fields
//            alu_op, alu_src_imm, reg_write, mem_read, mem_write,
//            branch, jump, illegal - control outputs
//  Rev     : 1.0  initial release
// ============================================================================
module instruction_decode
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_instruction,
  output logic            id_ready,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      alu_op,
  output logic            alu_src_imm,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic [2:0]      funct3,
  output logic            illegal
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            load;

  // --------------------------------------------------------------------------
  // Pipeline register control
  // --------------------------------------------------------------------------
  assign id_valid = (state_q == ST_FULL);
  assign id_ready = !id_valid || ex_ready;
  assign load     = if_valid && id_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (load) begin
      state_d = ST_FULL;
    end else if ((state_q == ST_FULL) && ex_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Data only moves on a load, so a stalled or flushed entry keeps its bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else if (load) begin
      pc_q    <= if_pc;
      instr_q <= if_instruction;
    end
  end

  // --------------------------------------------------------------------------
  // Field extraction
  // --------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [6:0] funct7;

  assign opcode = instr_q[6:0];
  assign funct7 = instr_q[31:25];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign id_pc  = pc_q;

  imm_gen u_imm_gen (
    .instruction (instr_q),
    .imm         (imm)
  );

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  alu_op_t alu_d;
  logic    src_imm_d;
  logic    rw_d;
  logic    mr_d;
  logic    mw_d;
  logic    br_d;
  logic    jp_d;
  logic    ill_d;

  // Maps funct3 to the shared R/I-ALU operation for the base funct7.
  function automatic alu_op_t base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  base_alu = ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  always_comb begin
    alu_d     = ALU_ADD;
    src_imm_d = 1'b0;
    rw_d      = 1'b0;
    mr_d      = 1'b0;
    mw_d      = 1'b0;
    br_d      = 1'b0;
    jp_d      = 1'b0;
    ill_d     = 1'b0;

    case (opcode)
      OPC_R: begin
        rw_d = 1'b1;
        if (funct7 == FUNCT7_BASE) begin
          alu_d = base_alu(funct3);
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
          alu_d = ALU_SUB;
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
          alu_d = ALU_SRA;
        end else if (funct7 == FUNCT7_MUL) begin
`ifdef DECODE_RV32M_EN
          // MUL..REMU are contiguous from 11 in funct3 order.
          alu_d = alu_op_t'(5'd11 + 5'(funct3));
`else
          ill_d = 1'b1;
`endif
        end else begin
          ill_d = 1'b1;
        end
      end
      OPC_I_ALU: begin
        rw_d      = 1'b1;
        src_imm_d = 1'b1;
        alu_d     = base_alu(funct3);
        // Shift-immediates reuse the funct7 slot: only SRAI may set bit 30.
        if (funct3 == 3'b001 && funct7 != FUNCT7_BASE) begin
          ill_d = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == FUNCT7_ALT) begin
            alu_d = ALU_SRA;
          end else if (funct7 != FUNCT7_BASE) begin
            ill_d = 1'b1;
          end
        end
      end
      OPC_LOAD: begin
        rw_d      = 1'b1;
        mr_d      = 1'b1;
        src_imm_d = 1'b1;
      end
      OPC_STORE: begin
        mw_d      = 1'b1;
        src_imm_d = 1'b1;
      end
      OPC_BRANCH: begin
        br_d = 1'b1;
        // BEQ/BNE compare by subtraction; BLT/BGE and BLTU/BGEU by set-less-than.
        case (funct3[2:1])
          2'b10:   alu_d = ALU_SLT;
          2'b11:   alu_d = ALU_SLTU;
          default: alu_d = ALU_SUB;
        endcase
      end
      OPC_JAL: begin
        rw_d      = 1'b1;
        jp_d      = 1'b1;
        src_imm_d = 1'b1;
      end
      OPC_JALR: begin
        rw_d      = 1'b1;
        jp_d      = 1'b1;
        src_imm_d = 1'b1;
        ill_d     = (funct3 != 3'b000);
      end
      OPC_LUI: begin
        rw_d      = 1'b1;
        src_imm_d = 1'b1;
        alu_d     = ALU_PASSB;
      end
      OPC_AUIPC: begin
        rw_d      = 1'b1;
        src_imm_d = 1'b1;
      end
      default: begin
        ill_d = 1'b1;
      end
    endcase

    // An illegal word must not cause any architectural side effect; the ALU
    // fields are also returned to their neutral values.
    if (ill_d) begin
      alu_d     = ALU_ADD;
      src_imm_d = 1'b0;
      rw_d      = 1'b0;
      mr_d      = 1'b0;
      mw_d      = 1'b0;
      br_d      = 1'b0;
      jp_d      = 1'b0;
    end
  end

  // Control flags are qualified by id_valid so an empty stage never requests
  // a write, and reads all-zero out of reset.
  assign alu_op      = alu_d;
  assign alu_src_imm = id_valid && src_imm_d;
  assign reg_write   = id_valid && rw_d;
  assign mem_read    = id_valid && mr_d;
  assign mem_write   = id_valid && mw_d;
  assign branch      = id_valid && br_d;
  assign jump        = id_valid && jp_d;
  assign illegal     = id_valid && ill_d;

endmodule
`default_nettype wire
